// File: rtl/imm_decode_pipe.sv
// Registered RISC-V immediate decoder with valid/ready output and a 2-entry skid buffer.
// Optional compressed (RVC) decode is enabled by defining IMM_RVC_EN.

module imm_decode_pipe_dec #(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm,
  output logic [2:0]      typ
);
  localparam logic [2:0] T_NONE = 3'd0, T_I = 3'd1, T_S = 3'd2, T_B = 3'd3,
                         T_U = 3'd4, T_J = 3'd5, T_SH = 3'd6;

  function automatic logic [XLEN-1:0] sx(input logic [31:0] v);
    return XLEN'($signed(v));
  endfunction

  logic [6:0] op;
  logic [2:0] f3;
  assign op = instr[6:0];
  assign f3 = instr[14:12];

  always_comb begin
    imm = '0;
    typ = T_NONE;
`ifdef IMM_RVC_EN
    if (instr[1:0] != 2'b11) begin
      // 16-bit encodings: quadrant in [1:0], funct3 in [15:13]
      case ({instr[1:0], instr[15:13]})
        5'b01_000, 5'b01_010: begin
          typ = T_I;
          imm = sx({{26{instr[12]}}, instr[12], instr[6:2]});
        end
        5'b01_101: begin
          typ = T_J;
          imm = sx({{20{instr[12]}}, instr[12], instr[8], instr[10:9], instr[6],
                    instr[7], instr[2], instr[11], instr[5:3], 1'b0});
        end
        5'b01_110, 5'b01_111: begin
          typ = T_B;
          imm = sx({{23{instr[12]}}, instr[12], instr[6:5], instr[2],
                    instr[11:10], instr[4:3], 1'b0});
        end
        5'b00_010: begin
          typ = T_I;
          imm = XLEN'({instr[5], instr[12:10], instr[6], 2'b00});
        end
        5'b00_110: begin
          typ = T_S;
          imm = XLEN'({instr[5], instr[12:10], instr[6], 2'b00});
        end
        default: ;
      endcase
    end else
`endif
    begin
      case (op)
        7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011, 7'b0011011: begin
          if (op == 7'b0011011 && XLEN != 64) begin
            typ = T_NONE;
          end else if ((op == 7'b0010011 || op == 7'b0011011) &&
                       (f3 == 3'b001 || f3 == 3'b101)) begin
            // shift amount only; funct7 bits stay out of the immediate
            typ = T_SH;
            if (XLEN == 32 || op == 7'b0011011) imm = XLEN'(instr[24:20]);
            else                                imm = XLEN'(instr[25:20]);
          end else begin
            typ = T_I;
            imm = sx({{20{instr[31]}}, instr[31:20]});
          end
        end
        7'b0100011: begin
          typ = T_S;
          imm = sx({{20{instr[31]}}, instr[31:25], instr[11:7]});
        end
        7'b1100011: begin
          typ = T_B;
          imm = sx({{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0});
        end
        7'b0110111, 7'b0010111: begin
          typ = T_U;
          imm = sx({instr[31:12], 12'b0});
        end
        7'b1101111: begin
          typ = T_J;
          imm = sx({{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0});
        end
        default: ;
      endcase
    end
  end
endmodule

module imm_decode_pipe #(
  parameter int              XLEN           = 32,
  parameter logic [XLEN-1:0] RESET_PC_FIELD = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_type,
  output logic [XLEN-1:0] out_target,
  output logic [XLEN-1:0] out_pc
);
  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [2:0]      typ;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] tgt;
  } ent_t;

  logic [XLEN-1:0] dec_imm;
  logic [2:0]      dec_typ;
  ent_t            in_ent, a_q, b_q, a_n, b_n;
  logic            a_vld, b_vld, a_vld_n, b_vld_n, rdy_q;
  logic            acc, hs;

  imm_decode_pipe_dec #(.XLEN(XLEN)) u_dec (
    .instr (in_instr),
    .imm   (dec_imm),
    .typ   (dec_typ)
  );

  always_comb begin
    in_ent.imm = dec_imm;
    in_ent.typ = dec_typ;
    in_ent.pc  = in_pc;
    in_ent.tgt = in_pc + dec_imm;
  end

  assign acc = in_valid & rdy_q;
  assign hs  = a_vld & out_ready;

  // A is the output register, B catches the one instruction accepted while A stalls
  always_comb begin
    a_n     = a_q;
    b_n     = b_q;
    a_vld_n = a_vld;
    b_vld_n = b_vld;
    if (flush) begin
      a_vld_n = 1'b0;
      b_vld_n = 1'b0;
    end else if (!a_vld || hs) begin
      if (b_vld) begin
        a_n     = b_q;
        a_vld_n = 1'b1;
        b_vld_n = acc;
        if (acc) b_n = in_ent;
      end else begin
        a_vld_n = acc;
        if (acc) a_n = in_ent;
      end
    end else if (acc) begin
      b_n     = in_ent;
      b_vld_n = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '{imm: '0, typ: '0, pc: RESET_PC_FIELD, tgt: '0};
      b_q   <= '{imm: '0, typ: '0, pc: RESET_PC_FIELD, tgt: '0};
      a_vld <= 1'b0;
      b_vld <= 1'b0;
      rdy_q <= 1'b1;
    end else begin
      a_q   <= a_n;
      b_q   <= b_n;
      a_vld <= a_vld_n;
      b_vld <= b_vld_n;
      rdy_q <= !b_vld_n;
    end
  end

  assign in_ready   = rdy_q;
  assign out_valid  = a_vld;
  assign out_imm    = a_q.imm;
  assign out_type   = a_q.typ;
  assign out_target = a_q.tgt;
  assign out_pc     = a_q.pc;
endmodule

// File: doc/imm_decode_pipe.md
Name: imm_decode_pipe

Overview:
Parametrised, registered successor to the combinational immediate decoder, sitting between fetch and the decode/issue stage.
- Extracts and sign-extends the RISC-V immediate at XLEN = 32 or 64 and classifies its format.
- Precomputes the PC-relative target (pc + imm).
- Presents results behind a valid/ready handshake with a 2-entry skid buffer, so backpressure never drops or reorders instructions.
- Supports pipeline flush.

Parameters:
- XLEN, 32, datapath width; legal values 32 or 64.
- RESET_PC_FIELD, 0, reset value of out_pc.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  discard all buffered entries and any same-cycle input
- in_valid  in  1  input instruction valid
- in_ready  out  1  block can accept input (registered)
- in_instr  in  32  instruction word
- in_pc  in  XLEN  instruction address
- out_valid  out  1  output entry valid
- out_ready  in  1  consumer accepts output
- out_imm  out  XLEN  decoded immediate
- out_type  out  3  0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 SHAMT
- out_target  out  XLEN  out_pc + out_imm, mod 2^XLEN
- out_pc  out  XLEN  pc of the output entry

Behaviour:
Reset (rst_n low, async):
- out_valid=0, in_ready=1, out_imm=0, out_type=0, out_target=0, out_pc=RESET_PC_FIELD.
- Both buffer entries are invalid.

Storage:
- Entry A is the output register; entry B is the skid register.
- Accept = in_valid & in_ready.
- Output handshake = out_valid & out_ready.
- in_ready next = !B_valid_next. in_ready is registered and has no combinational path from out_ready.

Latency and ordering:
- Accepted instruction appears on out_* the next cycle when A is empty or draining.
- If A is stalled, the accepted instruction goes to B. B moves to A on the next handshake.
- Strict FIFO order. Throughput is 1 per cycle with out_ready held high.

Simultaneous events:
- Handshake + accept in the same cycle with B empty: A is reloaded from input.
- Handshake + accept with B full is impossible because in_ready=0.

Flush:
- Highest priority. Next cycle: out_valid=0, B invalid, in_ready=1.
- Same-cycle input is dropped.
- Data fields hold their last values.

Decode is combinational on in_instr and captured at accept. The opcode field is in_instr[6:0].
- I (type 1): opcodes 0010011, 0000011, 1100111, 1110011, plus 0011011 when XLEN=64. imm = sext(instr[31:20]).
- SHAMT (type 6): opcode 0010011 (and 0011011) with funct3 = 001 or 101. imm = zext(instr[24:20]) when XLEN=32 or opcode 0011011; zext(instr[25:20]) when XLEN=64 and opcode 0010011. funct7 bits are never part of imm.
- S (type 2): opcode 0100011. imm = sext({instr[31:25], instr[11:7]}).
- B (type 3): opcode 1100011. imm = sext({instr[31], instr[7], instr[30:25], instr[11:8], 0}).
- U (type 4): opcodes 0110111, 0010111. imm = sext({instr[31:12], 12'b0}) to XLEN.
- J (type 5): opcode 1101111. imm = sext({instr[31], instr[19:12], instr[20], instr[30:21], 0}).
- Any other opcode: type 0, imm = 0.
- out_target is computed for every type and wraps modulo 2^XLEN.

Optional Feature:
Macro IMM_RVC_EN.
- Defined: in_instr[1:0] != 2'b11 is treated as 16-bit compressed (upper half ignored). Encodings (quadrant, funct3):
  - C.ADDI / C.LI (01, 000/010) -> I, sext({i[12], i[6:2]}).
  - C.J (01, 101) -> J, sext({i[12], i[8], i[10:9], i[6], i[7], i[2], i[11], i[5:3], 0}).
  - C.BEQZ / C.BNEZ (01, 110/111) -> B, sext({i[12], i[6:5], i[2], i[11:10], i[4:3], 0}).
  - C.LW (00, 010) -> I, zext({i[5], i[12:10], i[6], 2'b00}).
  - C.SW (00, 110) -> S, same immediate as C.LW.
  - Other compressed encodings -> type 0, imm 0.
- Undefined: no compressed logic. Such words fall through the 32-bit opcode decode (type 0, imm 0).

Test Plan:
1. XLEN=32, ADDI 0xFFF00093, pc 0x100, out_ready=1 -> next cycle out_valid=1, imm 0xFFFFFFFF, type 1, target 0x000000FF.
2. JAL 0x0080006F, pc 0x1000 -> imm 0x8, type 5, target 0x1008. Back-to-back BEQ stream at 1/cycle shows no bubbles.
3. out_ready=0 while driving 3 valid instrs -> first 2 accepted, in_ready=0 from the cycle after the 2nd accept. Release out_ready -> all 3 emerge in order, none lost or duplicated.
4. Both entries full, assert flush with in_valid=1 -> next cycle out_valid=0, in_ready=1, flushed input never appears. Async reset mid-stall -> out_valid=0 immediately.
5. XLEN=64:
   - SRAI 0x4210D093 -> imm 0x21, type 6.
   - LUI 0x800000B7 -> imm 0xFFFFFFFF80000000, type 4.
   - pc 0xFFFFFFFFFFFFFFF0, imm 0x20 -> target 0x10 (wrap).
6. C.LI 0x000050FD -> with IMM_RVC_EN: imm 0xFFFFFFFF, type 1. Without the macro: type 0, imm 0.
